// File: rtl/div_unit_if.sv
// div_unit_if: EX-stage divide request (op, operands, start/annul) and its
// HI/LO result, ready pulse and stall request.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic [7:0]         alucontrol;
  logic               start;
  logic               annul;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               stall;

  modport master (
    output alucontrol, start, annul, a, b,
    input  result, ready, stall
  );

  modport slave (
    input  alucontrol, start, annul, a, b,
    output result, ready, stall
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring DIV/DIVU, {remainder, quotient} for HI/LO; optional DIV_EARLY_OUT_EN.
// Latency: ready 33 cycles after start, 2 on divide-by-zero, 1 when |b|>|a| with DIV_EARLY_OUT_EN.
// Backpressure: none accepted; stall holds the pipeline while busy, annul cancels an in-flight divide.
`ifndef EXE_DIV_OP
`define EXE_DIV_OP  8'b00011010
`endif
`ifndef EXE_DIVU_OP
`define EXE_DIVU_OP 8'b00011011
`endif

module div_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
  logic               signed_q, sa_q, sx_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic               is_div, is_signed, go, early, no_borrow, stall;
  logic [WIDTH-1:0]   a_mag, b_mag, rem_nx, quo_nx, rem_fix, quo_fix;
  logic [WIDTH:0]     pr, sub;
  logic               unused_sub_msb;

  assign is_div    = (bus.alucontrol == `EXE_DIV_OP) || (bus.alucontrol == `EXE_DIVU_OP);
  assign is_signed = (bus.alucontrol == `EXE_DIV_OP);
  assign a_mag     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign go        = (state_q == IDLE) && bus.start && is_div && !bus.annul;

`ifdef DIV_EARLY_OUT_EN
  assign early = (b_mag > a_mag);
`else
  assign early = 1'b0;
`endif

  // quo_q starts as the dividend; its MSB is shifted into the partial remainder each step
  assign pr             = {rem_q, quo_q[WIDTH-1]};
  assign sub            = pr - {1'b0, dvs_q};
  assign no_borrow      = (pr >= {1'b0, dvs_q});
  assign rem_nx         = no_borrow ? sub[WIDTH-1:0] : pr[WIDTH-1:0];
  assign quo_nx         = {quo_q[WIDTH-2:0], no_borrow};
  assign unused_sub_msb = sub[WIDTH];

  assign rem_fix = (signed_q && sa_q) ? -rem_nx : rem_nx;
  assign quo_fix = (signed_q && sx_q) ? -quo_nx : quo_nx;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = bus.start && is_div;
        if (go) begin
          if (bus.b == '0)  state_d = DIVZERO;
          else if (early)   state_d = END;
          else              state_d = ON;
        end
      end
      DIVZERO: begin
        stall   = 1'b1;
        state_d = bus.annul ? IDLE : END;
      end
      ON: begin
        stall = 1'b1;
        if (bus.annul)            state_d = IDLE;
        else if (cnt_q == LAST)   state_d = END;
      end
      END:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      signed_q <= 1'b0;
      sa_q     <= 1'b0;
      sx_q     <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == END);
      case (state_q)
        IDLE: begin
          if (go) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= a_mag;
            dvs_q    <= b_mag;
            signed_q <= is_signed;
            sa_q     <= bus.a[WIDTH-1];
            sx_q     <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            if (state_d == END) result_q <= {bus.a, {WIDTH{1'b0}}};
          end
        end
        ON: begin
          cnt_q <= cnt_q + 1'b1;
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          if (state_d == END) result_q <= {rem_fix, quo_fix};
        end
        DIVZERO: begin
          if (state_d == END) result_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = ready_q;
  assign bus.stall  = stall;
endmodule
